// File: rtl/game_timer_ctrl_pkg.sv
// Shared types and constants for the round timer sequencing controller.
package game_timer_ctrl_pkg;
   localparam int TIMER_W          = 8;
   localparam int DEF_PRESCALE_DIV = 1000000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSED  = 2'd2,
      EXPIRED = 2'd3
   } state_t;
endpackage

// File: rtl/game_timer_ctrl_tick_prescaler.sv
// Divides clk down to timer ticks: tick is combinational on the held count, one cycle in PRESCALE_DIV while run.
// Latency: zero cycles from count to tick; no backpressure, zero always wins over run.
module game_timer_ctrl_tick_prescaler
   import game_timer_ctrl_pkg::*;
#(
   parameter int PRESCALE_W   = 20,
   parameter int PRESCALE_DIV = DEF_PRESCALE_DIV
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic zero,
   output logic tick
);

   localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE_DIV - 1);

   logic [PRESCALE_W-1:0] count;

   assign tick = run && !zero && (count == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (zero) begin
         count <= '0;
      end else if (run) begin
         count <= (count == LAST) ? '0 : count + PRESCALE_W'(1);
      end
   end

endmodule

// File: rtl/game_timer_ctrl.sv
// Round timer sequencer: drives the external counter's enable/clear and flags time-up at the latched limit.
// Latency: all outputs registered, one cycle after the deciding inputs; no backpressure.
module game_timer_ctrl
   import game_timer_ctrl_pkg::*;
#(
   parameter int PRESCALE_W   = 20,
   parameter int PRESCALE_DIV = DEF_PRESCALE_DIV
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic               pause,
   input  logic               resume,
   input  logic               frog_home,
   input  logic [TIMER_W-1:0] limit,
   input  logic [TIMER_W-1:0] cnt_value,
   output logic               cnt_enable,
   output logic               cnt_clear,
   output logic               time_up,
   output logic               running,
   output logic [1:0]         state
);

   state_t             state_q;
   state_t             state_d;
   logic [TIMER_W-1:0] limit_q;
   logic               hit;
   logic               tick;
   logic               run;
   logic               zero;
   logic               latch;
   logic               clear_d;
   logic               time_up_d;

   game_timer_ctrl_tick_prescaler #(
      .PRESCALE_W   (PRESCALE_W),
      .PRESCALE_DIV (PRESCALE_DIV)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .run   (run),
      .zero  (zero),
      .tick  (tick)
   );

   // While cnt_clear is high the returned count is stale, so it must not be compared.
   assign hit = (state_q == RUN) && !cnt_clear && (cnt_value == limit_q);

   always_comb begin
      state_d   = state_q;
      run       = 1'b0;
      zero      = 1'b0;
      latch     = 1'b0;
      clear_d   = 1'b0;
      time_up_d = 1'b0;
      if (abort) begin
         state_d = IDLE;
         zero    = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_d = RUN;
                  latch   = 1'b1;
                  zero    = 1'b1;
               end
            end
            RUN: begin
               if (frog_home) begin
                  latch   = 1'b1;
                  zero    = 1'b1;
                  clear_d = 1'b1;
               end else if (hit) begin
                  state_d   = EXPIRED;
                  time_up_d = 1'b1;
               end else if (pause) begin
                  state_d = PAUSED;
               end else begin
                  run = 1'b1;
               end
            end
            PAUSED: begin
               if (frog_home) begin
                  state_d = RUN;
                  latch   = 1'b1;
                  zero    = 1'b1;
                  clear_d = 1'b1;
               end else if (resume) begin
                  state_d = RUN;
               end
            end
            EXPIRED: begin
               if (start) begin
                  state_d = RUN;
                  latch   = 1'b1;
                  zero    = 1'b1;
                  clear_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      if (state_d == IDLE) begin
         clear_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         limit_q    <= '0;
         cnt_enable <= 1'b0;
         cnt_clear  <= 1'b1;
         time_up    <= 1'b0;
         running    <= 1'b0;
      end else begin
         state_q    <= state_d;
         if (latch) begin
            limit_q <= limit;
         end
         // run is only high on cycles with no clear, hit or pause, so tick needs no further gating.
         cnt_enable <= tick;
         cnt_clear  <= clear_d;
         time_up    <= time_up_d;
         running    <= (state_d == RUN);
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl: attached 8-bit counter, directed scenarios plus random traffic vs a cycle model.
module tb_game_timer_ctrl;
   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0, abort = 1'b0, pause = 1'b0, resume = 1'b0, frog_home = 1'b0;
   logic [7:0] limit = 8'd0;
   logic [7:0] tb_cnt = 8'd0;
   logic       cnt_enable, cnt_clear, time_up, running;
   logic [1:0] state;

   int vectors = 0, miscompares = 0;
   int m_state, m_pre, m_lim, m_cnt;
   bit m_clr, m_en, m_tu;
   int en_seen, tu_seen, max_cnt, en_snap;

   always #5 clk = ~clk;

   game_timer_ctrl #(.PRESCALE_W(8), .PRESCALE_DIV(DIV)) dut (
      .clk(clk), .reset(rst_n), .start(start), .abort(abort), .pause(pause),
      .resume(resume), .frog_home(frog_home), .limit(limit), .cnt_value(tb_cnt),
      .cnt_enable(cnt_enable), .cnt_clear(cnt_clear), .time_up(time_up),
      .running(running), .state(state)
   );

   // The timer counter instance this controller drives.
   always @(posedge clk) begin
      if (cnt_clear) tb_cnt <= 8'd0;
      else if (cnt_enable) tb_cnt <= tb_cnt + 8'd1;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_pre = 0; m_lim = 0; m_clr = 1; m_en = 0; m_tu = 0;
   endtask

   // Applies the round rules in priority order: abort, frog_home, limit hit, then start/pause/resume.
   task automatic model_step();
      int n_cnt, n_s, n_p, n_l;
      bit hit, n_clr, n_en, n_tu;
      n_cnt = m_clr ? 0 : (m_en ? (m_cnt + 1) % 256 : m_cnt);
      if (!rst_n) begin
         model_reset();
      end else begin
         hit = (m_state == 1) && !m_clr && (m_cnt == m_lim);
         n_s = m_state; n_p = m_pre; n_l = m_lim; n_clr = 0; n_en = 0; n_tu = 0;
         if (abort) begin
            n_s = 0; n_p = 0;
         end else if (frog_home && (m_state == 1 || m_state == 2)) begin
            n_s = 1; n_clr = 1; n_p = 0; n_l = int'(limit);
         end else if (hit) begin
            n_s = 3; n_tu = 1;
         end else if (start && (m_state == 0 || m_state == 3)) begin
            n_s = 1; n_clr = (m_state == 3); n_p = 0; n_l = int'(limit);
         end else if (m_state == 1 && pause) begin
            n_s = 2;
         end else if (m_state == 2 && resume) begin
            n_s = 1;
         end else if (m_state == 1) begin
            if (m_pre == DIV - 1) begin n_en = 1; n_p = 0; end
            else n_p = m_pre + 1;
         end
         if (n_s == 0) n_clr = 1;
         m_state = n_s; m_pre = n_p; m_lim = n_l; m_clr = n_clr; m_en = n_en; m_tu = n_tu;
      end
      m_cnt = n_cnt;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".state"},   8'(state),      8'(m_state));
      chk({tag, ".enable"},  8'(cnt_enable), 8'(m_en));
      chk({tag, ".clear"},   8'(cnt_clear),  8'(m_clr));
      chk({tag, ".time_up"}, 8'(time_up),    8'(m_tu));
      chk({tag, ".running"}, 8'(running),    8'(m_state == 1));
      chk({tag, ".count"},   tb_cnt,         8'(m_cnt));
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
      en_seen += int'(cnt_enable);
      tu_seen += int'(time_up);
      if (int'(tb_cnt) > max_cnt) max_cnt = int'(tb_cnt);
   endtask

   task automatic run(input int n, input string tag);
      repeat (n) cycle(tag);
   endtask

   task automatic run_until_cnt(input logic [7:0] target, input int bound, input string tag);
      int k = 0;
      while (tb_cnt != target && k < bound) begin
         cycle(tag);
         k++;
      end
      chk({tag, ".reach"}, tb_cnt, target);
   endtask

   task automatic clear_stats();
      en_seen = 0; tu_seen = 0; max_cnt = 0;
   endtask

   task automatic pulse(input string which, input string tag);
      case (which)
         "start":  start = 1'b1;
         "abort":  abort = 1'b1;
         "pause":  pause = 1'b1;
         "resume": resume = 1'b1;
         default:  frog_home = 1'b1;
      endcase
      cycle(tag);
      start = 1'b0; abort = 1'b0; pause = 1'b0; resume = 1'b0; frog_home = 1'b0;
   endtask

   initial begin
      model_reset();
      m_cnt = 0;
      clear_stats();
      #1 rst_n = 1'b0;
      #1;
      check_all("reset");
      run(3, "rst_hold");
      rst_n = 1'b1;
      run(2, "idle");

      // 1: plain round, limit 5
      clear_stats();
      limit = 8'd5; pulse("start", "t1");
      run(30, "t1");
      chk("t1.state_end", 8'(state), 8'd3);
      chk("t1.enables", 8'(en_seen), 8'd5);
      chk("t1.time_up_cnt", 8'(tu_seen), 8'd1);
      chk("t1.max_count", 8'(max_cnt), 8'd5);

      // 2: pause at count 2 for 10 cycles
      pulse("abort", "t2"); run(2, "t2");
      clear_stats();
      pulse("start", "t2");
      run_until_cnt(8'd2, 30, "t2a");
      pulse("pause", "t2p");
      en_snap = en_seen;
      run(10, "t2hold");
      chk("t2.paused_enables", 8'(en_seen - en_snap), 8'd0);
      chk("t2.paused_state", 8'(state), 8'd2);
      pulse("resume", "t2r");
      run(30, "t2b");
      chk("t2.enables", 8'(en_seen), 8'd5);
      chk("t2.time_up_cnt", 8'(tu_seen), 8'd1);
      chk("t2.count_end", tb_cnt, 8'd5);

      // 3: frog_home at 4 with a new limit of 7
      pulse("abort", "t3"); run(2, "t3");
      clear_stats();
      limit = 8'd5; pulse("start", "t3");
      run_until_cnt(8'd4, 30, "t3a");
      limit = 8'd7; pulse("frog", "t3f");
      chk("t3.clear_pulse", 8'(cnt_clear), 8'd1);
      cycle("t3c");
      chk("t3.count_cleared", tb_cnt, 8'd0);
      chk("t3.clear_drop", 8'(cnt_clear), 8'd0);
      run(40, "t3b");
      chk("t3.state_end", 8'(state), 8'd3);
      chk("t3.count_end", tb_cnt, 8'd7);
      chk("t3.time_up_cnt", 8'(tu_seen), 8'd1);

      // 4: frog_home in the same cycle as the limit hit
      pulse("abort", "t4"); run(2, "t4");
      clear_stats();
      limit = 8'd2; pulse("start", "t4");
      run_until_cnt(8'd2, 30, "t4a");
      pulse("frog", "t4f");
      chk("t4.state", 8'(state), 8'd1);
      chk("t4.time_up", 8'(time_up), 8'd0);
      chk("t4.clear", 8'(cnt_clear), 8'd1);
      cycle("t4c");
      chk("t4.count_cleared", tb_cnt, 8'd0);
      chk("t4.time_up_cnt", 8'(tu_seen), 8'd0);

      // 5: asynchronous reset mid-round
      pulse("abort", "t5"); run(2, "t5");
      limit = 8'd9; pulse("start", "t5");
      run_until_cnt(8'd3, 30, "t5a");
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("t5.async_state", 8'(state), 8'd0);
      chk("t5.async_enable", 8'(cnt_enable), 8'd0);
      chk("t5.async_clear", 8'(cnt_clear), 8'd1);
      chk("t5.async_time_up", 8'(time_up), 8'd0);
      chk("t5.async_running", 8'(running), 8'd0);
      cycle("t5rst");
      rst_n = 1'b1;
      cycle("t5rel");
      chk("t5.rel_state", 8'(state), 8'd0);
      chk("t5.rel_clear", 8'(cnt_clear), 8'd1);
      chk("t5.rel_count", tb_cnt, 8'd0);

      // 6: abort from PAUSED, then a zero-limit round
      limit = 8'd5; pulse("start", "t6");
      run(6, "t6");
      pulse("pause", "t6p");
      chk("t6.paused", 8'(state), 8'd2);
      pulse("abort", "t6a");
      chk("t6.idle", 8'(state), 8'd0);
      cycle("t6");
      clear_stats();
      limit = 8'd0; pulse("start", "t6s");
      chk("t6.run", 8'(state), 8'd1);
      run(8, "t6b");
      chk("t6.enables", 8'(en_seen), 8'd0);
      chk("t6.time_up_cnt", 8'(tu_seen), 8'd1);
      chk("t6.state_end", 8'(state), 8'd3);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         start     = ($urandom % 8) == 0;
         abort     = ($urandom % 40) == 0;
         pause     = ($urandom % 12) == 0;
         resume    = ($urandom % 6) == 0;
         frog_home = ($urandom % 25) == 0;
         limit     = 8'($urandom_range(0, 7));
         cycle("rnd");
      end
      start = 1'b0; abort = 1'b0; pause = 1'b0; resume = 1'b0; frog_home = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
